async_fifo_unit: RTL and testbench

- Single-clock, parameterised first-in-first-out buffer with full, almost-full, empty and almost-empty status flags.
- Used as a rate-decoupling queue between a producer and a consumer that share one clock.
- Write-side and read-side signals keep w_/r_ prefixes so the block can later be swapped for a dual-clock version without interface changes.

---
 rtl/async_fifo_unit.sv | 88 ++++++++
 tb/tb_async_fifo_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/async_fifo_unit.sv
// Single-clock FIFO with registered data output and registered full/almost-full/
// empty/almost-empty flags computed from next-state pointers.
module async_fifo_unit #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             w_en,
   input  logic [WIDTH-1:0] i_dat,
   output logic             w_full,
   output logic             w_almost_full,
   input  logic             r_en,
   output logic [WIDTH-1:0] o_dat,
   output logic             r_empty,
   output logic             r_almost_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] AFULL_CNT  = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] AEMPTY_CNT = (AW+1)'(1);

   // Handshake: a write is accepted when w_en=1 and w_full=0; a read is
   // accepted when r_en=1 and r_empty=0. Refused requests are silently dropped.

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [AW:0]      count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             full_q, full_d;
   logic             afull_q, afull_d;
   logic             empty_q, empty_d;
   logic             aempty_q, aempty_d;
   logic             wr_acc, rd_acc;

   assign wr_acc = w_en & ~full_q;
   assign rd_acc = r_en & ~empty_q;

   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      dout_d   = dout_q;
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) begin
         rptr_d = rptr_q + 1'b1;
         dout_d = mem_q[rptr_q[AW-1:0]];
      end
      // Occupancy wraps naturally in AW+1 bits, giving 0..DEPTH.
      count_d  = wptr_d - rptr_d;
      empty_d  = (wptr_d == rptr_d);
      full_d   = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
      afull_d  = (count_d >= AFULL_CNT);
      aempty_d = (count_d <= AEMPTY_CNT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         dout_q   <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         empty_q  <= 1'b1;
         aempty_q <= 1'b1;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         dout_q   <= dout_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         empty_q  <= empty_d;
         aempty_q <= aempty_d;
      end
   end

   // Storage is not cleared by reset; reset only blocks writes on its cycle.
   always_ff @(posedge clk) begin
      if (rst_n && wr_acc) mem_q[wptr_q[AW-1:0]] <= i_dat;
   end

   assign w_full         = full_q;
   assign w_almost_full  = afull_q;
   assign r_empty        = empty_q;
   assign r_almost_empty = aempty_q;
   assign o_dat          = dout_q;

endmodule

// File: tb/tb_async_fifo_unit.sv
// Self-checking bench for async_fifo_unit: a reference queue models occupancy,
// a scoreboard queue holds expected read data.
module tb_async_fifo_unit;

   localparam int WIDTH = 5;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             w_en, r_en;
   logic [WIDTH-1:0] i_dat, o_dat;
   logic             w_full, w_almost_full, r_empty, r_almost_empty;

   logic [WIDTH-1:0] exp_q [$];
   logic [WIDTH-1:0] model_q [$];
   logic [WIDTH-1:0] last_dout;
   int               n_total = 0;
   int               n_bad   = 0;

   async_fifo_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .w_en           (w_en),
      .i_dat          (i_dat),
      .w_full         (w_full),
      .w_almost_full  (w_almost_full),
      .r_en           (r_en),
      .o_dat          (o_dat),
      .r_empty        (r_empty),
      .r_almost_empty (r_almost_empty)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100us;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic check_flags(input string tag);
      int cnt;
      cnt = model_q.size();
      check({tag, "_empty"},  32'(r_empty),        32'(cnt == 0));
      check({tag, "_aempty"}, 32'(r_almost_empty), 32'(cnt <= 1));
      check({tag, "_full"},   32'(w_full),         32'(cnt == DEPTH));
      check({tag, "_afull"},  32'(w_almost_full),  32'(cnt >= DEPTH - 1));
   endtask

   // driver: one clock with the given requests, then score the result
   task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r);
      bit wacc, racc;
      w_en = w; i_dat = d; r_en = r;
      @(posedge clk);
      wacc = w && (model_q.size() < DEPTH);
      racc = r && (model_q.size() > 0);
      if (racc) exp_q.push_back(model_q.pop_front());
      if (wacc) model_q.push_back(d);
      #1;
      if (racc) begin
         last_dout = exp_q.pop_front();
         check("rd_data", 32'(o_dat), 32'(last_dout));
      end else begin
         check("dout_hold", 32'(o_dat), 32'(last_dout));
      end
      check_flags("flags");
   endtask

   task automatic do_reset(input int cycles, input logic w, input logic r);
      rst_n = 1'b0; w_en = w; r_en = r; i_dat = 5'd7;
      repeat (cycles) @(posedge clk);
      #1;
      model_q.delete();
      exp_q.delete();
      last_dout = '0;
      rst_n = 1'b1; w_en = 1'b0; r_en = 1'b0;
      check("rst_dout", 32'(o_dat), 32'd0);
      check_flags("rst");
   endtask

   initial begin
      rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; i_dat = '0; last_dout = '0;

      // reset
      do_reset(2, 1'b0, 1'b0);

      // overfill: 21 writes, only 16 accepted
      for (int i = 0; i < 21; i++) begin
         step(1'b1, WIDTH'(i), 1'b0);
         if (i == 0)  check("empty_fall_1st", 32'(r_empty), 32'd0);
         if (i == 1)  check("aempty_fall_2nd", 32'(r_almost_empty), 32'd0);
         if (i == 14) check("afull_rise_15th", 32'(w_almost_full), 32'd1);
         if (i == 15) check("full_rise_16th", 32'(w_full), 32'd1);
      end

      // drain past empty
      for (int i = 0; i < 21; i++) step(1'b0, '0, 1'b1);
      check("dout_stuck_15", 32'(o_dat), 32'd15);

      // wrap-around
      for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(20 + i), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, WIDTH'(100 + i), 1'b0);
      check("wrap_full", 32'(w_full), 32'd1);
      for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
      check("wrap_last", 32'(o_dat), 32'((100 + 15) % 32));

      // simultaneous read/write at 8 words
      for (int i = 0; i < 8; i++) step(1'b1, WIDTH'($urandom_range(0, 31)), 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, WIDTH'($urandom_range(0, 31)), 1'b1);
      check("sim_count8", 32'(model_q.size()), 32'd8);

      // simultaneous when full: only the read happens
      for (int i = 0; i < 8; i++) step(1'b1, WIDTH'($urandom_range(0, 31)), 1'b0);
      check("pre_full", 32'(w_full), 32'd1);
      step(1'b1, 5'd31, 1'b1);
      check("full_rw_nfull", 32'(w_full), 32'd0);

      // simultaneous when empty: write only, no bypass
      for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);
      step(1'b1, 5'd9, 1'b1);
      check("empty_rw_nobypass", 32'(r_empty), 32'd0);
      step(1'b0, '0, 1'b1);
      check("empty_rw_data", 32'(o_dat), 32'd9);

      // mid-operation reset with 5 words, requests active during reset
      for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(i + 3), 1'b0);
      do_reset(1, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1);
      check("post_rst_read", 32'(o_dat), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
